// File: rtl/cs_window_decoder.sv
// Programmable base/mask chip-select decoder for a 6502 bus, with fixed-priority
// active-low selects, optional PHI2 qualification and a per-window RDY wait-state generator.
module cs_window_decoder #(
    parameter int                ADDR_BITS = 5,
    parameter int                NUM_CS    = 4,
    parameter int                WS_BITS   = 2,
    parameter logic [NUM_CS-1:0] PHI2_QUAL = 4'b0001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 phi2,
    input  logic [ADDR_BITS-1:0] addr_hi,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_ch,
    input  logic [1:0]           cfg_field,
    input  logic [ADDR_BITS-1:0] cfg_data,
    output logic [NUM_CS-1:0]    cs_n,
    output logic                 rdy,
    output logic                 busy
);

    // state  | meaning
    // S_IDLE | decoding freely, waiting for a PHI2 rise on a window with wait states
    // S_WAIT | RDY held low, counting down the winning window's wait states
    // S_HOLD | RDY released, waiting for PHI2 low so one phase cannot retrigger
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WS_BITS-1:0]   r_cnt;
    logic [WS_BITS-1:0]   w_cnt_nxt;
    logic                 r_phi2_q;
    logic [NUM_CS-1:0]    r_cs_n;

    logic [ADDR_BITS-1:0] r_base [NUM_CS];
    logic [ADDR_BITS-1:0] r_mask [NUM_CS];
    logic [WS_BITS-1:0]   r_ws   [NUM_CS];
    logic [NUM_CS-1:0]    r_en;

    logic [NUM_CS-1:0]    w_match;
    logic [NUM_CS-1:0]    w_win_oh;
    logic                 w_hit;
    logic                 w_win_qual;
    logic [WS_BITS-1:0]   w_win_ws;
    logic [NUM_CS-1:0]    w_cs_n_nxt;
    logic                 w_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CS; i++) begin
                r_base[i] <= '0;
                r_mask[i] <= '0;
                r_ws[i]   <= '0;
            end
            r_en <= '0;
        end else if (cfg_we) begin
            // out-of-range channels simply never compare equal
            for (int i = 0; i < NUM_CS; i++) begin
                if (cfg_ch == 3'(i)) begin
                    case (cfg_field)
                        2'd0: r_base[i] <= cfg_data;
                        2'd1: r_mask[i] <= cfg_data;
                        2'd2: begin
                            r_ws[i] <= cfg_data[WS_BITS-1:0];
                            r_en[i] <= cfg_data[ADDR_BITS-1];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        w_match    = '0;
        w_hit      = 1'b0;
        w_win_qual = 1'b0;
        w_win_ws   = '0;
        w_win_oh   = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            w_match[i] = r_en[i] && (((addr_hi ^ r_base[i]) & r_mask[i]) == '0);
        end
        // descending scan so the lowest matching index is the last one written
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit       = 1'b1;
                w_win_qual  = PHI2_QUAL[i];
                w_win_ws    = r_ws[i];
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
            end
        end
        w_cs_n_nxt = '1;
        if (w_hit && (!w_win_qual || phi2)) begin
            w_cs_n_nxt = ~w_win_oh;
        end
    end

    assign w_rise = phi2 & ~r_phi2_q;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_rise && w_hit && (w_win_ws != '0)) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = w_win_ws;
                end
            end
            S_WAIT: begin
                if (r_cnt == WS_BITS'(1)) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - WS_BITS'(1);
                end
            end
            S_HOLD: begin
                if (!phi2) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_phi2_q <= 1'b0;
            r_cs_n   <= '1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_phi2_q <= phi2;
            // selects stay frozen for the whole stall so the bus may move underneath
            if (r_state == S_IDLE) begin
                r_cs_n <= w_cs_n_nxt;
            end
        end
    end

    assign cs_n = r_cs_n;
    assign rdy  = (r_state != S_WAIT);
    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_cs_window_decoder.sv
// Self-checking bench for cs_window_decoder: directed scenarios plus random traffic
// compared against a window/stall-counter reference model.
module tb_cs_window_decoder;

    localparam logic [3:0] QUAL = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       phi2;
    logic [4:0] addr_hi;
    logic       cfg_we;
    logic [2:0] cfg_ch;
    logic [1:0] cfg_field;
    logic [4:0] cfg_data;
    logic [3:0] cs_n;
    logic       rdy;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    cs_window_decoder #(
        .ADDR_BITS(5), .NUM_CS(4), .WS_BITS(2), .PHI2_QUAL(QUAL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .phi2(phi2), .addr_hi(addr_hi),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_field(cfg_field), .cfg_data(cfg_data),
        .cs_n(cs_n), .rdy(rdy), .busy(busy)
    );

    always #5 clk = ~clk;

    // reference model: window table plus "cycles of stall left" and a hold flag
    logic [4:0] m_base [4];
    logic [4:0] m_mask [4];
    int         m_ws   [4];
    bit         m_en   [4];
    logic [3:0] m_cs_n;
    bit         m_phi2_q;
    int         m_stall_left;
    bit         m_holding;

    function automatic int ref_winner();
        for (int i = 0; i < 4; i++) begin
            if (m_en[i] && (((addr_hi ^ m_base[i]) & m_mask[i]) == 5'd0)) return i;
        end
        return -1;
    endfunction

    function automatic logic m_rdy();
        return (m_stall_left == 0);
    endfunction

    function automatic logic m_busy();
        return (m_stall_left > 0) || m_holding;
    endfunction

    task automatic model_edge();
        int w;
        bit rise;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_base[i] = '0; m_mask[i] = '0; m_ws[i] = 0; m_en[i] = 0;
            end
            m_cs_n = 4'hF; m_phi2_q = 0; m_stall_left = 0; m_holding = 0;
        end else begin
            w    = ref_winner();
            rise = phi2 && !m_phi2_q;
            if (!m_busy()) begin
                if (w < 0 || (QUAL[w] && !phi2)) m_cs_n = 4'hF;
                else                             m_cs_n = ~(4'b0001 << w);
            end
            if (m_stall_left > 0) begin
                m_stall_left--;
                if (m_stall_left == 0) m_holding = 1;
            end else if (m_holding) begin
                if (!phi2) m_holding = 0;
            end else if (rise && w >= 0 && m_ws[w] > 0) begin
                m_stall_left = m_ws[w];
            end
            if (cfg_we && cfg_ch < 3'd4) begin
                case (cfg_field)
                    2'd0: m_base[cfg_ch] = cfg_data;
                    2'd1: m_mask[cfg_ch] = cfg_data;
                    2'd2: begin m_ws[cfg_ch] = int'(cfg_data[1:0]); m_en[cfg_ch] = cfg_data[4]; end
                    default: ;
                endcase
            end
            m_phi2_q = phi2;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [1:0] fld, input logic [4:0] data);
        cfg_we = 1; cfg_ch = ch; cfg_field = fld; cfg_data = data;
        tick();
        cfg_we = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; cfg_we = 0; cfg_ch = 0; cfg_field = 0; cfg_data = 0;
        for (int i = 0; i < 2; i++) begin
            addr_hi = 5'($urandom); phi2 = 1'($urandom);
            tick();
        end
        n_checks++;
        if ({cs_n, rdy, busy} !== {4'hF, 1'b1, 1'b0})
            $display("FAIL reset_state got cs_n=%b rdy=%b busy=%b exp cs_n=1111 rdy=1 busy=0", cs_n, rdy, busy);
        else n_pass++;
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            addr_hi = 5'($urandom); phi2 = 1'($urandom);
            tick();
            n_checks++;
            if (cs_n !== 4'hF) $display("FAIL reset_nomatch got cs_n=%b exp 1111", cs_n);
            else n_pass++;
        end
    endtask

    task automatic test_legacy_map();
        logic [4:0] ta [5];
        logic       tp [5];
        logic [3:0] te [5];
        ta = '{5'b01100, 5'b00010, 5'b00010, 5'b01100, 5'b10101};
        tp = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b1};
        te = '{4'hF,     4'hF,     4'b1110,  4'b1110,  4'hF};
        phi2 = 0;
        cfg_write(3'd0, 2'd0, 5'b00000);
        cfg_write(3'd0, 2'd1, 5'b10000);
        cfg_write(3'd0, 2'd2, 5'b10000);
        cfg_write(3'd1, 2'd0, 5'b01000);
        cfg_write(3'd1, 2'd1, 5'b11000);
        cfg_write(3'd1, 2'd2, 5'b10000);
        for (int i = 0; i < 5; i++) begin
            addr_hi = ta[i]; phi2 = tp[i];
            tick();
            n_checks++;
            if (cs_n !== te[i] || cs_n !== m_cs_n)
                $display("FAIL legacy_map[%0d] got cs_n=%b exp %b", i, cs_n, te[i]);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        phi2 = 0;
        cfg_write(3'd2, 2'd1, 5'b00000);
        cfg_write(3'd2, 2'd2, 5'b10000);
        cfg_write(3'd3, 2'd1, 5'b00000);
        cfg_write(3'd3, 2'd2, 5'b10000);
        for (int i = 0; i < 12; i++) begin
            addr_hi = 5'($urandom);
            if (i % 2 == 0) addr_hi[4] = 1'b1;
            phi2 = 1'($urandom);
            tick();
            n_checks++;
            if ({cs_n, rdy, busy} !== {m_cs_n, m_rdy(), m_busy()} || $countones(~cs_n) > 1)
                $display("FAIL priority[%0d] got cs_n=%b rdy=%b busy=%b exp cs_n=%b rdy=%b busy=%b",
                         i, cs_n, rdy, busy, m_cs_n, m_rdy(), m_busy());
            else n_pass++;
            if (i % 2 == 0) begin
                n_checks++;
                if (cs_n !== 4'b1011) $display("FAIL priority_ch2[%0d] got cs_n=%b exp 1011", i, cs_n);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wait_states();
        logic ps [5];
        int   low_cnt;
        ps = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        phi2 = 0;
        cfg_write(3'd0, 2'd2, 5'b00000);
        cfg_write(3'd1, 2'd2, 5'b10011);
        addr_hi = 5'b01000;
        tick();
        phi2 = 1;
        tick();
        low_cnt = rdy ? 0 : 1;
        n_checks++;
        if ({cs_n, rdy, busy} !== {4'b1101, 1'b0, 1'b1})
            $display("FAIL ws_trigger got cs_n=%b rdy=%b busy=%b exp cs_n=1101 rdy=0 busy=1", cs_n, rdy, busy);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            addr_hi = 5'($urandom); phi2 = ps[i];
            tick();
            if (!rdy) low_cnt++;
            n_checks++;
            if ({cs_n, rdy, busy} !== {m_cs_n, m_rdy(), m_busy()} || cs_n !== 4'b1101)
                $display("FAIL ws_step[%0d] got cs_n=%b rdy=%b busy=%b exp cs_n=1101 rdy=%b busy=%b",
                         i, cs_n, rdy, busy, m_rdy(), m_busy());
            else n_pass++;
            if (i == 3) begin
                n_checks++;
                if (busy !== 1'b1) $display("FAIL ws_hold_busy got busy=%b exp 1", busy);
                else n_pass++;
            end
        end
        n_checks++;
        if (low_cnt != 3 || busy !== 1'b0)
            $display("FAIL ws_length got rdy_low=%0d busy=%b exp rdy_low=3 busy=0", low_cnt, busy);
        else n_pass++;
    endtask

    task automatic test_ws_zero();
        phi2 = 0; addr_hi = 5'b10110;
        tick();
        for (int i = 0; i < 3; i++) begin
            phi2 = (i != 2) ? 1'b1 : 1'b0;
            tick();
            n_checks++;
            if ({cs_n, rdy, busy} !== {4'b1011, 1'b1, 1'b0})
                $display("FAIL ws_zero[%0d] got cs_n=%b rdy=%b busy=%b exp cs_n=1011 rdy=1 busy=0", i, cs_n, rdy, busy);
            else n_pass++;
        end
    endtask

    task automatic test_cfg_collision();
        int low_cnt;
        phi2 = 0; addr_hi = 5'b01000;
        tick();
        phi2 = 1;
        cfg_write(3'd1, 2'd2, 5'b10001);
        low_cnt = rdy ? 0 : 1;
        phi2 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!rdy) low_cnt++;
        end
        n_checks++;
        if (low_cnt != 3 || busy !== 1'b0)
            $display("FAIL collision_old_ws got rdy_low=%0d busy=%b exp rdy_low=3 busy=0", low_cnt, busy);
        else n_pass++;
        cfg_write(3'd5, 2'd2, 5'b10011);
        cfg_write(3'd1, 2'd3, 5'b10011);
        phi2 = 1;
        tick();
        low_cnt = rdy ? 0 : 1;
        phi2 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!rdy) low_cnt++;
        end
        n_checks++;
        if (low_cnt != 1 || m_stall_left != 0)
            $display("FAIL collision_new_ws got rdy_low=%0d exp rdy_low=1", low_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_ch    = 3'($urandom);
            cfg_field = 2'($urandom);
            cfg_data  = 5'($urandom);
            addr_hi   = 5'($urandom);
            phi2      = 1'($urandom);
            tick();
            n_checks++;
            if ({cs_n, rdy, busy} !== {m_cs_n, m_rdy(), m_busy()} || $countones(~cs_n) > 1)
                $display("FAIL random[%0d] got cs_n=%b rdy=%b busy=%b exp cs_n=%b rdy=%b busy=%b",
                         i, cs_n, rdy, busy, m_cs_n, m_rdy(), m_busy());
            else n_pass++;
        end
        rst_n = 1; cfg_we = 0;
    endtask

    task automatic test_reset_mid_stall();
        phi2 = 0;
        for (int c = 0; c < 4; c++) cfg_write(3'(c), 2'd2, 5'b00000);
        cfg_write(3'd1, 2'd0, 5'b01000);
        cfg_write(3'd1, 2'd1, 5'b11000);
        cfg_write(3'd1, 2'd2, 5'b10011);
        addr_hi = 5'b01000;
        tick();
        phi2 = 1;
        tick();
        tick();
        n_checks++;
        if ({cs_n, rdy, busy} !== {4'b1101, 1'b0, 1'b1})
            $display("FAIL mid_stall_pre got cs_n=%b rdy=%b busy=%b exp cs_n=1101 rdy=0 busy=1", cs_n, rdy, busy);
        else n_pass++;
        rst_n = 0;
        tick();
        n_checks++;
        if ({cs_n, rdy, busy} !== {4'hF, 1'b1, 1'b0})
            $display("FAIL mid_stall_reset got cs_n=%b rdy=%b busy=%b exp cs_n=1111 rdy=1 busy=0", cs_n, rdy, busy);
        else n_pass++;
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            addr_hi = (i == 0) ? 5'b01000 : 5'($urandom);
            phi2 = 1'b1;
            tick();
            n_checks++;
            if ({cs_n, rdy, busy} !== {4'hF, 1'b1, 1'b0})
                $display("FAIL post_reset_disabled[%0d] got cs_n=%b rdy=%b busy=%b exp cs_n=1111 rdy=1 busy=0",
                         i, cs_n, rdy, busy);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 0; phi2 = 0; addr_hi = '0;
        cfg_we = 0; cfg_ch = '0; cfg_field = '0; cfg_data = '0;
        test_reset();
        test_legacy_map();
        test_priority();
        test_wait_states();
        test_ws_zero();
        test_cfg_collision();
        test_random();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
